rpn_operand_stack: RTL and testbench

//  Parametrised LIFO operand stack for the RPN ALU datapath, generalising the fixed 8-bit load-enable register.

---
 rtl/rpn_operand_stack_pkg.sv | 19 +
 rtl/rpn_operand_stack_if.sv | 34 +++
 rtl/rpn_operand_stack_reg_load_n.sv | 25 ++
 rtl/rpn_operand_stack.sv | 101 ++++++++++
 tb/tb_rpn_operand_stack.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/rpn_operand_stack_pkg.sv
// Shared definitions for the RPN operand stack and its control FSM.
// Op encodings are {PUSH,POP}.
package rpn_operand_stack_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } op_e;

  function automatic logic op_removes(op_e op);
    return (op == OP_POP) || (op == OP_REPL);
  endfunction

endpackage

// File: rtl/rpn_operand_stack_if.sv
// Request/status bundle between the RPN control FSM and the operand stack.
// The master issues push/pop/replace requests and observes the operands.
interface rpn_operand_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);

  localparam int CW = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] d;
  logic             clear_err;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] next;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, d, clear_err,
    input  top, next, count, empty, full,
    input  overflow, underflow
  );

  modport slave (
    input  push, pop, d, clear_err,
    output top, next, count, empty, full,
    output overflow, underflow
  );

endinterface

// File: rtl/rpn_operand_stack_reg_load_n.sv
// WIDTH-bit storage register with load enable and
// synchronous active-low clear.
module reg_load_n #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_clr_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/rpn_operand_stack.sv
// LIFO operand stack exposing the top two entries to the ALU.
// Supports push, pop and replace with sticky overflow/underflow flags.
module rpn_operand_stack
  import rpn_operand_stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  rpn_operand_stack_if.slave  io_stk
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             r_unf;

  op_e              w_op;
  logic             w_full;
  logic             w_empty;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic             w_ovf_ev;
  logic             w_unf_ev;
  logic [DEPTH-1:0] w_load;
  logic [WIDTH-1:0] w_q [DEPTH];
  logic [WIDTH-1:0] w_top;
  logic [WIDTH-1:0] w_next;

  assign w_op      = op_e'({io_stk.push, io_stk.pop});
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push_ok = (w_op == OP_PUSH) && !w_full;
  assign w_pop_ok  = (w_op == OP_POP) && !w_empty;
  assign w_ovf_ev  = (w_op == OP_PUSH) && w_full;
  assign w_unf_ev  = op_removes(w_op) && w_empty;

  // Replace targets the current top, i.e. entry COUNT-1.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign w_load[g] =
      (w_push_ok && (r_count == CW'(g))) ||
      ((w_op == OP_REPL) && (r_count == CW'(g + 1)));

    reg_load_n #(.WIDTH(WIDTH)) u_ent (
      .i_clk   (i_clk),
      .i_clr_n (i_rst_n),
      .i_load  (w_load[g]),
      .i_d     (io_stk.d),
      .o_q     (w_q[g])
    );
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop_ok) begin
        r_count <= r_count - CW'(1);
      end
      // A fresh error outranks a clear in the same cycle.
      if (w_ovf_ev) begin
        r_ovf <= 1'b1;
      end else if (io_stk.clear_err) begin
        r_ovf <= 1'b0;
      end
      if (w_unf_ev) begin
        r_unf <= 1'b1;
      end else if (io_stk.clear_err) begin
        r_unf <= 1'b0;
      end
    end
  end

  always_comb begin
    w_top  = '0;
    w_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_count == CW'(i + 1)) begin
        w_top = w_q[i];
      end
      if (r_count == CW'(i + 2)) begin
        w_next = w_q[i];
      end
    end
  end

  assign io_stk.top       = w_top;
  assign io_stk.next      = w_next;
  assign io_stk.count     = r_count;
  assign io_stk.empty     = w_empty;
  assign io_stk.full      = w_full;
  assign io_stk.overflow  = r_ovf;
  assign io_stk.underflow = r_unf;

endmodule

// File: tb/tb_rpn_operand_stack.sv
// Scoreboard bench for rpn_operand_stack (WIDTH=8, DEPTH=4).
// Directed ops queue expected state; a negedge monitor compares.
module tb_rpn_operand_stack;

  typedef struct packed {
    logic [7:0] top;
    logic [7:0] next;
    logic [2:0] count;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       unf;
  } exp_t;

  logic  clk;
  logic  rst_n;
  exp_t  q_exp [$];
  string q_nm  [$];
  int    checks;
  int    errors;

  rpn_operand_stack_if #(.WIDTH(8), .DEPTH(4)) stk ();

  rpn_operand_stack #(.WIDTH(8), .DEPTH(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_stk  (stk.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic op(
    input logic       rn,
    input logic       p,
    input logic       q,
    input logic [7:0] d,
    input logic       clr,
    input logic [7:0] e_top,
    input logic [7:0] e_next,
    input int         e_cnt,
    input logic       e_ovf,
    input logic       e_unf,
    input string      nm
  );
    exp_t e;
    @(negedge clk);
    rst_n         = rn;
    stk.push      = p;
    stk.pop       = q;
    stk.d         = d;
    stk.clear_err = clr;
    @(posedge clk);
    e.top   = e_top;
    e.next  = e_next;
    e.count = 3'(e_cnt);
    e.empty = (e_cnt == 0);
    e.full  = (e_cnt == 4);
    e.ovf   = e_ovf;
    e.unf   = e_unf;
    q_exp.push_back(e);
    q_nm.push_back(nm);
  endtask

  // Monitor: compare the queued expectation one half-cycle after each edge.
  initial begin
    exp_t e;
    exp_t a;
    string nm;
    forever begin
      @(negedge clk);
      if (q_exp.size() > 0) begin
        e  = q_exp.pop_front();
        nm = q_nm.pop_front();
        a.top   = stk.top;
        a.next  = stk.next;
        a.count = stk.count;
        a.empty = stk.empty;
        a.full  = stk.full;
        a.ovf   = stk.overflow;
        a.unf   = stk.underflow;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s got top=%h next=%h cnt=%0d e=%b f=%b o=%b u=%b required top=%h next=%h cnt=%0d e=%b f=%b o=%b u=%b",
            nm, a.top, a.next, a.count, a.empty, a.full, a.ovf, a.unf,
            e.top, e.next, e.count, e.empty, e.full, e.ovf, e.unf);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    stk.push      = 1'b0;
    stk.pop       = 1'b0;
    stk.d         = 8'h00;
    stk.clear_err = 1'b0;

    // reset held with push asserted
    op(0, 1, 0, 8'hAA, 0, 8'h00, 8'h00, 0, 0, 0, "rst_a");
    op(0, 1, 0, 8'hAA, 0, 8'h00, 8'h00, 0, 0, 0, "rst_b");
    op(1, 1, 0, 8'h11, 0, 8'h11, 8'h00, 1, 0, 0, "push11");

    // fill and overflow
    op(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, "rst2");
    op(1, 1, 0, 8'h01, 0, 8'h01, 8'h00, 1, 0, 0, "fill1");
    op(1, 1, 0, 8'h02, 0, 8'h02, 8'h01, 2, 0, 0, "fill2");
    op(1, 1, 0, 8'h03, 0, 8'h03, 8'h02, 3, 0, 0, "fill3");
    op(1, 1, 0, 8'h04, 0, 8'h04, 8'h03, 4, 0, 0, "fill4");
    op(1, 1, 0, 8'h55, 0, 8'h04, 8'h03, 4, 1, 0, "ovf");
    op(1, 1, 1, 8'h99, 0, 8'h99, 8'h03, 4, 1, 0, "repl_full");
    op(1, 0, 0, 8'h00, 0, 8'h99, 8'h03, 4, 1, 0, "hold");

    // underflow
    op(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, "rst3");
    op(1, 0, 1, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1, "unf_pop");
    op(1, 1, 1, 8'h07, 0, 8'h00, 8'h00, 0, 0, 1, "unf_repl");
    op(1, 0, 0, 8'h00, 1, 8'h00, 8'h00, 0, 0, 0, "clr_unf");

    // "3 4 +"
    op(1, 1, 0, 8'h03, 0, 8'h03, 8'h00, 1, 0, 0, "rpn_p3");
    op(1, 1, 0, 8'h04, 0, 8'h04, 8'h03, 2, 0, 0, "rpn_p4");
    op(1, 0, 1, 8'h00, 0, 8'h03, 8'h00, 1, 0, 0, "rpn_pop");
    op(1, 1, 1, 8'h07, 0, 8'h07, 8'h00, 1, 0, 0, "rpn_repl");
    op(1, 1, 0, 8'h20, 0, 8'h20, 8'h07, 2, 0, 0, "push20");
    op(1, 0, 1, 8'h00, 0, 8'h07, 8'h00, 1, 0, 0, "stale");

    // clear vs. error collision
    op(1, 1, 0, 8'h0A, 0, 8'h0A, 8'h07, 2, 0, 0, "f_a");
    op(1, 1, 0, 8'h0B, 0, 8'h0B, 8'h0A, 3, 0, 0, "f_b");
    op(1, 1, 0, 8'h0C, 0, 8'h0C, 8'h0B, 4, 0, 0, "f_c");
    op(1, 1, 0, 8'hEE, 1, 8'h0C, 8'h0B, 4, 1, 0, "ovf_clr");
    op(1, 0, 0, 8'h00, 1, 8'h0C, 8'h0B, 4, 0, 0, "clr_ovf");
    op(1, 1, 1, 8'hDD, 0, 8'hDD, 8'h0B, 4, 0, 0, "repl_no_ovf");

    // mid-operation reset
    op(1, 0, 1, 8'h00, 0, 8'h0B, 8'h0A, 3, 0, 0, "pop_to3");
    op(0, 1, 0, 8'h33, 0, 8'h00, 8'h00, 0, 0, 0, "rst_mid");
    op(1, 0, 1, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1, "unf_after");
    op(1, 1, 0, 8'h5A, 0, 8'h5A, 8'h00, 1, 0, 1, "push_sticky");

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending required 0", q_exp.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
